// File: rtl/mod_counter.sv
// Modulo up/down counter with clamped synchronous load, registered terminal-count
// pulse, sticky wrap/underflow flags and an optional prescaler (MOD_COUNTER_PRESCALE_EN).
module mod_counter #(
  parameter int WIDTH     = 8,
  parameter int MODULO    = 256,
  parameter int THRESHOLD = MODULO - 1,
  parameter int PRESCALE  = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             clr_flags_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             underflow_o,
  output logic             at_max_o
);

  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH:0] THR_W = (WIDTH+1)'(THRESHOLD);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             wrap_q, wrap_d;
  logic             underflow_q, underflow_d;
  logic             step;

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   load_ext;

  assign count_ext = {1'b0, count_q};
  assign load_ext  = {1'b0, load_val_i};

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  assign step = en_i && (pre_q == PRE_LAST);

  // Load restarts the prescale period so a fresh PRESCALE enables are needed.
  always_comb begin
    pre_d = pre_q;
    if (load_i) begin
      pre_d = '0;
    end else if (en_i) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = (PRESCALE != 0);
  assign step = en_i;
`endif

  always_comb begin
    count_d     = count_q;
    tc_d        = 1'b0;
    wrap_d      = wrap_q;
    underflow_d = underflow_q;

    if (clr_flags_i) begin
      wrap_d      = 1'b0;
      underflow_d = 1'b0;
    end

    if (load_i) begin
      count_d = (load_ext >= MOD_W) ? MAX_W[WIDTH-1:0] : load_val_i;
    end else if (step) begin
      if (up_i) begin
        if (count_ext == MAX_W) begin
          count_d = '0;
          tc_d    = 1'b1;
          wrap_d  = 1'b1;
        end else begin
          count_d = WIDTH'(count_ext + 1'b1);
        end
      end else begin
        if (count_ext == '0) begin
          count_d     = MAX_W[WIDTH-1:0];
          tc_d        = 1'b1;
          underflow_d = 1'b1;
        end else begin
          count_d = WIDTH'(count_ext - 1'b1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q     <= '0;
      tc_q        <= 1'b0;
      wrap_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      tc_q        <= tc_d;
      wrap_q      <= wrap_d;
      underflow_q <= underflow_d;
    end
  end

  assign count_o     = count_q;
  assign tc_o        = tc_q;
  assign wrap_o      = wrap_q;
  assign underflow_o = underflow_q;
  assign at_max_o    = (count_ext >= THR_W);

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter (MODULO=10, THRESHOLD=7, PRESCALE=3).
module tb_mod_counter;

  localparam int WIDTH = 8;

  logic             clk_sys = 1'b0;
  logic             rst_n   = 1'b0;
  logic             en      = 1'b0;
  logic             up      = 1'b1;
  logic             load    = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             clr_flags = 1'b0;
  logic [WIDTH-1:0] count;
  logic             tc, wrap, underflow, at_max;

  int n_chk  = 0;
  int n_pass = 0;

  mod_counter #(
    .WIDTH(WIDTH), .MODULO(10), .THRESHOLD(7), .PRESCALE(3)
  ) u_dut (
    .clk_i(clk_sys), .rst_n_i(rst_n), .en_i(en), .up_i(up), .load_i(load),
    .load_val_i(load_val), .clr_flags_i(clr_flags), .count_o(count),
    .tc_o(tc), .wrap_o(wrap), .underflow_o(underflow), .at_max_o(at_max)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_state(input string tag, input int c, input int t, input int w,
                           input int u, input int m);
    chk({tag, " count"}, int'(count), c);
    chk({tag, " tc"}, int'(tc), t);
    chk({tag, " wrap"}, int'(wrap), w);
    chk({tag, " underflow"}, int'(underflow), u);
    chk({tag, " at_max"}, int'(at_max), m);
  endtask

  initial begin
    #12;
    chk_state("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // up wrap: 12 steps from 0
    up = 1'b1; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk_state($sformatf("up%0d", i), i % 10, (i == 10) ? 1 : 0, (i >= 10) ? 1 : 0, 0,
                ((i % 10) >= 7) ? 1 : 0);
    end

    // reach 6 then async reset between edges
    for (int i = 0; i < 4; i++) tick();
    en = 1'b0;
    chk_state("pre_rst", 6, 0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_state("async_rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // set wrap, then down wrap with clr_flags on the same edge
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk_state("wrap_set", 0, 1, 1, 0, 0);
    up = 1'b0; clr_flags = 1'b1;
    tick();
    chk_state("down_wrap_clr", 9, 1, 0, 1, 1);
    en = 1'b0; clr_flags = 1'b0;
    tick();
    chk_state("down_hold", 9, 0, 0, 1, 1);
    clr_flags = 1'b1;
    tick();
    chk_state("clr_only", 9, 0, 0, 0, 1);
    clr_flags = 1'b0;

    // load clamp and plain load, with wrap flag set beforehand
    en = 1'b1; up = 1'b1;
    tick();
    chk_state("wrap_again", 0, 1, 1, 0, 0);
    load = 1'b1; load_val = 8'd15;
    tick();
    chk_state("load_clamp", 9, 0, 1, 0, 1);
    load_val = 8'd3;
    tick();
    chk_state("load3", 3, 0, 1, 0, 0);
    load = 1'b0;
    for (int i = 4; i <= 9; i++) begin
      tick();
      chk($sformatf("thr count%0d", i), int'(count), i);
      chk($sformatf("thr at_max%0d", i), int'(at_max), (i >= 7) ? 1 : 0);
    end

`ifdef MOD_COUNTER_PRESCALE_EN
    load = 1'b1; load_val = 8'd2; en = 1'b0;
    tick();
    load = 1'b0;
    en = 1'b1; tick(); chk("pre en1", int'(count), 2);
    en = 1'b0; tick(); chk("pre en0", int'(count), 2);
    en = 1'b1; tick(); chk("pre en2", int'(count), 2);
    tick();            chk("pre en3 step", int'(count), 3);
    tick();            chk("pre mid", int'(count), 3);
    load = 1'b1; load_val = 8'd5;
    tick();            chk("pre load", int'(count), 5);
    load = 1'b0;
    tick();            chk("pre restart1", int'(count), 5);
    tick();            chk("pre restart2", int'(count), 5);
    tick();            chk("pre restart3", int'(count), 6);
`else
    load = 1'b1; load_val = 8'd2; en = 1'b0;
    tick();
    load = 1'b0;
    en = 1'b1; tick(); chk("nopre en1", int'(count), 3);
    en = 1'b0; tick(); chk("nopre en0", int'(count), 3);
    en = 1'b1; tick(); chk("nopre en2", int'(count), 4);
`endif
    en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter, the next generation of the basic keyboard-FPGA counter. It adds a programmable modulus, count direction, synchronous load, an optional input prescaler, a one-cycle terminal-count pulse and clearable sticky wrap/underflow flags. It serves scan-row sequencing, debounce timing and key-repeat intervals in the keyboard FPGA, replacing ad-hoc counters.

## Interface
- `WIDTH`, 8: count register width in bits.
- `MODULO`, 256: count range is 0..MODULO-1. Legal range is 2 ≤ MODULO ≤ 2^WIDTH.
- `THRESHOLD`, MODULO-1: compare point for `at_max`.
- `PRESCALE`, 1: number of `en` cycles per count step. Must be ≥ 1. Used only with the prescaler macro.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset. Asserted when 0.
- `en` in 1: count enable, sampled each `clk`.
- `up` in 1: direction. 1 counts up, 0 counts down.
- `load` in 1: synchronous load strobe.
- `load_val` in WIDTH: value taken on `load`.
- `clr_flags` in 1: synchronous clear of `wrap` and `underflow`.
- `count` out WIDTH: current count.
- `tc` out 1: one-cycle terminal-count pulse.
- `wrap` out 1: sticky; set on an up-count wrap MODULO-1 → 0.
- `underflow` out 1: sticky; set on a down-count wrap 0 → MODULO-1.
- `at_max` out 1: `count` ≥ THRESHOLD. Combinational from the `count` register.

## Operation
- **Reset** (`rst`=0, asynchronous): `count`=0, `tc`=0, `wrap`=0, `underflow`=0, prescaler=0. `at_max` follows `count`, so it reads 0 unless THRESHOLD=0. Reset mid-operation discards all state immediately.
- **Step**: a step occurs when `en`=1 and the prescaler is at its terminal value (see Configuration).
- **Priority per edge**: `load` first, then step, else hold.
- **Load**:
  - `count` ← `load_val`. If `load_val` ≥ MODULO, `count` ← MODULO-1 (clamped).
  - Prescaler resets to 0.
  - No `tc` pulse and no flag change.
  - `load` with `en`=1 performs the load only.
- **Up step**:
  - `count`=MODULO-1 → 0, setting `wrap` and `tc`.
  - Otherwise `count`+1.
- **Down step**:
  - `count`=0 → MODULO-1, setting `underflow` and `tc`.
  - Otherwise `count`-1.
- **Arithmetic**: performed in WIDTH+1 bits internally. `count` never holds a value ≥ MODULO.
- **Flags**:
  - `clr_flags` clears `wrap` and `underflow`.
  - If a wrap occurs on the same edge as `clr_flags`, set wins for the flag being set. The other flag is cleared.
- **Direction change**: `up` may change on any cycle and takes effect on the next step. No state is reserved.

## Timing
- Count latency: 1 cycle. `count` updates on the rising edge where the step is taken.
- `tc` is registered. It is high for exactly the one cycle following the wrapping edge, aligned with the wrapped `count` value.
- Consecutive wrap steps (MODULO=2, continuous `en`) produce `tc` on every wrapping edge, with no gaps.
- Flags become visible 1 cycle after the wrapping edge and hold until `clr_flags` or reset.
- `at_max` has zero-cycle latency relative to `count`.

## Configuration
- Macro: `MOD_COUNTER_PRESCALE_EN`.
- **Defined**:
  - An internal prescaler counts `en` cycles 0..PRESCALE-1.
  - A step occurs on the `en` cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - `en`=0 holds the prescaler.
  - `load` zeroes the prescaler.
  - PRESCALE=1 behaves identically to the macro being undefined.
- **Undefined**: no prescaler logic is synthesised. Every `en`=1 cycle is a step and PRESCALE is ignored.

## Test plan
- **Reset**: WIDTH=8, MODULO=10. Pulse `rst` low mid-count at `count`=6, asynchronously between edges → `count`=0, `tc`=0, `wrap`=0 immediately, before the next edge.
- **Up wrap**: MODULO=10, `up`=1, `en` held for 12 cycles from 0 → `count` sequence 1..9, 0, 1, 2. `tc` high exactly one cycle, with `count`=0. `wrap`=1 from then on.
- **Down wrap with flag clear**: `up`=0 from 0, with `clr_flags` on the same edge → `count`=9, `underflow`=1 (set wins), `tc` pulse. Then `clr_flags` alone → `underflow`=0.
- **Load**: `load_val`=15, MODULO=10, `load`=`en`=1 → `count`=9, no `tc`, flags unchanged. `load_val`=3 → `count`=3.
- **Threshold**: THRESHOLD=7 → `at_max` is 0 at `count`=6 and 1 at `count`=7, 8 and 9, in the same cycle as `count`.
- **Prescaler**: with the macro defined, PRESCALE=3 and `en` toggling 1, 0, 1, 1 → one step after the third `en`=1 cycle only. `load` mid-prescale restarts the 3-cycle count.
